// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera configuration sequencer.
// Imported by the sequencer top and its wait timer.
package cam_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWDN,
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_DELAY,
        ST_WRITE,
        ST_RETRY,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [15:0] TBL_END   = 16'hFFFF;
    localparam logic [7:0]  REG_DELAY = 8'hFE;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cam_cfg_timer.sv
// Down-counting wait timer shared by the PWDN, RST and DELAY waits.
// Loading N gives an expired pulse N cycles after the load cycle.
module cam_cfg_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic         run_q;

    assign expired_o = run_q && (cnt_q == '0);

    // Counter: a load always wins over an expiry in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
            run_q <= 1'b1;
        end else if (expired_o) begin
            run_q <= 1'b0;
        end else if (run_q) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/cam_cfg_seq.sv
// Camera power-up sequencer and SCCB register-table walker.
// Outputs cam_pwdn/cam_rstn/busy are decoded from the state register.
module cam_cfg_seq
    import cam_cfg_pkg::*;
#(
    parameter int TBL_DEPTH      = 128,
    parameter int PWDN_WAIT_CYC  = 1_000_000,
    parameter int RST_WAIT_CYC   = 2_000_000,
    parameter int DELAY_UNIT_CYC = 100_000,
    parameter int MAX_RETRY      = 3,
    parameter int AUTO_START     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [$clog2(TBL_DEPTH)-1:0] err_index,
    output logic [7:0]                   wr_count,
    output logic                         cam_pwdn,
    output logic                         cam_rstn,
    output logic [$clog2(TBL_DEPTH)-1:0] tbl_addr,
    input  logic [15:0]                  tbl_data,
    output logic                         sccb_req,
    output logic [7:0]                   sccb_reg,
    output logic [7:0]                   sccb_wdata,
    input  logic                         sccb_ack,
    input  logic                         sccb_nack
);

    localparam int AW    = $clog2(TBL_DEPTH);
    localparam int TW    = $clog2(max3(PWDN_WAIT_CYC, RST_WAIT_CYC,
                                       DELAY_UNIT_CYC));
    localparam int RST_H = RST_WAIT_CYC / 2;
    localparam int RST_L = RST_WAIT_CYC - RST_H;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   eidx_q, eidx_d;
    logic [7:0]      wr_q, wr_d;
    logic [7:0]      retry_q, retry_d;
    logic [7:0]      units_q, units_d;
    logic            half_q, half_d;
    logic            auto_q, auto_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            req_q, req_d;
    logic [7:0]      reg_q, reg_d;
    logic [7:0]      wdat_q, wdat_d;
    logic            go;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_exp;

    cam_cfg_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_exp)
    );

    // Next-state logic: sequencing, table decode and SCCB handshake.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        eidx_d   = eidx_q;
        wr_d     = wr_q;
        retry_d  = retry_q;
        units_d  = units_q;
        half_d   = half_q;
        auto_d   = auto_q;
        done_d   = done_q;
        err_d    = err_q;
        req_d    = req_q;
        reg_d    = reg_q;
        wdat_d   = wdat_q;
        go       = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: go = start || auto_q;
            ST_PWDN: begin
                if (tmr_exp) begin
                    state_d  = ST_RST;
                    half_d   = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(RST_H - 1);
                end
            end
            ST_RST: begin
                if (tmr_exp && !half_q) begin
                    half_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(RST_L - 1);
                end else if (tmr_exp) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (tbl_data == TBL_END) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (tbl_data[15:8] == REG_DELAY) begin
                    if (tbl_data[7:0] == 8'd0) begin
                        state_d = ST_NEXT;
                    end else begin
                        state_d  = ST_DELAY;
                        units_d  = tbl_data[7:0];
                        tmr_load = 1'b1;
                        tmr_val  = TW'(DELAY_UNIT_CYC - 1);
                    end
                end else begin
                    state_d = ST_WRITE;
                    reg_d   = tbl_data[15:8];
                    wdat_d  = tbl_data[7:0];
                    req_d   = 1'b1;
                end
            end
            ST_DELAY: begin
                if (tmr_exp && units_q == 8'd1) begin
                    state_d = ST_NEXT;
                end else if (tmr_exp) begin
                    units_d  = units_q - 8'd1;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(DELAY_UNIT_CYC - 1);
                end
            end
            ST_WRITE: begin
                if (sccb_ack) begin
                    req_d = 1'b0;
                    if (!sccb_nack) begin
                        state_d = ST_NEXT;
                        retry_d = 8'd0;
                        if (wr_q != 8'hFF) wr_d = wr_q + 8'd1;
                    end else if (retry_q < 8'(MAX_RETRY)) begin
                        state_d = ST_RETRY;
                        retry_d = retry_q + 8'd1;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                        eidx_d  = addr_q;
                    end
                end
            end
            ST_RETRY: begin
                state_d = ST_WRITE;
                req_d   = 1'b1;
            end
            ST_NEXT: begin
                if (addr_q == AW'(TBL_DEPTH - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                    addr_d  = addr_q + 1'b1;
                end
            end
            ST_DONE, ST_ERROR: go = start;
            default: state_d = ST_IDLE;
        endcase
        if (go) begin
            state_d  = ST_PWDN;
            auto_d   = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b0;
            wr_d     = 8'd0;
            retry_d  = 8'd0;
            addr_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = TW'(PWDN_WAIT_CYC - 1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            eidx_q  <= '0;
            wr_q    <= 8'd0;
            retry_q <= 8'd0;
            units_q <= 8'd0;
            half_q  <= 1'b0;
            auto_q  <= (AUTO_START != 0);
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            reg_q   <= 8'd0;
            wdat_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            eidx_q  <= eidx_d;
            wr_q    <= wr_d;
            retry_q <= retry_d;
            units_q <= units_d;
            half_q  <= half_d;
            auto_q  <= auto_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            reg_q   <= reg_d;
            wdat_q  <= wdat_d;
        end
    end

    assign busy       = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign cam_pwdn   = (state_q inside {ST_IDLE, ST_PWDN});
    assign cam_rstn   = !(state_q inside {ST_IDLE, ST_PWDN}) &&
                        !(state_q == ST_RST && !half_q);
    assign done       = done_q;
    assign error      = err_q;
    assign err_index  = eidx_q;
    assign wr_count   = wr_q;
    assign tbl_addr   = addr_q;
    assign sccb_req   = req_q;
    assign sccb_reg   = reg_q;
    assign sccb_wdata = wdat_q;

endmodule

// File: tb/tb_cam_cfg_seq.sv
// Self-checking bench for cam_cfg_seq with short wait parameters.
// Table-driven runs plus start/reset corner sequences mid-write.
module tb_cam_cfg_seq;

    localparam int DEPTH   = 8;
    localparam int PWDN    = 20;
    localparam int RSTW    = 30;
    localparam int UNIT    = 10;
    localparam int ACK_DLY = 20;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy, done, error;
    logic [2:0]  err_index;
    logic [7:0]  wr_count;
    logic        cam_pwdn, cam_rstn;
    logic [2:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic        sccb_req;
    logic [7:0]  sccb_reg, sccb_wdata;
    logic        sccb_ack, sccb_nack;

    cam_cfg_seq #(
        .TBL_DEPTH      (DEPTH),
        .PWDN_WAIT_CYC  (PWDN),
        .RST_WAIT_CYC   (RSTW),
        .DELAY_UNIT_CYC (UNIT),
        .MAX_RETRY      (3),
        .AUTO_START     (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_index  (err_index),
        .wr_count   (wr_count),
        .cam_pwdn   (cam_pwdn),
        .cam_rstn   (cam_rstn),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .sccb_req   (sccb_req),
        .sccb_reg   (sccb_reg),
        .sccb_wdata (sccb_wdata),
        .sccb_ack   (sccb_ack),
        .sccb_nack  (sccb_nack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous table ROM: data one cycle after address.
    logic [15:0] tbl [DEPTH];
    always @(posedge clk) tbl_data <= tbl[tbl_addr];

    // SCCB slave model: ack ACK_DLY cycles into a request.
    logic [7:0] nack_reg;
    int         rcnt;
    always @(posedge clk) begin
        if (reset) begin
            sccb_ack  <= 1'b0;
            sccb_nack <= 1'b0;
            rcnt      <= 0;
        end else begin
            sccb_ack  <= 1'b0;
            sccb_nack <= 1'b0;
            if (sccb_req && !sccb_ack) begin
                if (rcnt == ACK_DLY - 1) begin
                    sccb_ack  <= 1'b1;
                    sccb_nack <= (sccb_reg == nack_reg);
                    rcnt      <= 0;
                end else begin
                    rcnt <= rcnt + 1;
                end
            end else begin
                rcnt <= 0;
            end
        end
    end

    // Event monitor: edge times and a log of requests.
    int         cyc;
    int         n_req;
    logic [7:0] reg_log [64];
    logic [7:0] val_log [64];
    int         rise_log [64];
    int         busy_rise, pwdn_fall, rstn_rise;
    logic       req_p, busy_p, pwdn_p, rstn_p;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        req_p  <= sccb_req;
        busy_p <= busy;
        pwdn_p <= cam_pwdn;
        rstn_p <= cam_rstn;
        if (!reset && sccb_req && req_p === 1'b0 && n_req < 64) begin
            reg_log[n_req]  <= sccb_reg;
            val_log[n_req]  <= sccb_wdata;
            rise_log[n_req] <= cyc;
            n_req           <= n_req + 1;
        end
        if (busy && busy_p === 1'b0) busy_rise <= cyc;
        if (!cam_pwdn && pwdn_p === 1'b1) pwdn_fall <= cyc;
        if (cam_rstn && rstn_p === 1'b0) rstn_rise <= cyc;
    end

    int n_pass;
    int n_tot;

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        n_tot = n_tot + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    task automatic wait_end(input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (done || error) hit = 1'b1;
        end
        chk(nm, 32'(hit), 32'd1);
    endtask

    task automatic wait_req(input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (sccb_req) hit = 1'b1;
        end
        chk(nm, 32'(hit), 32'd1);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    typedef struct {
        logic [15:0] t [DEPTH];
        logic [7:0]  nack;
        logic        exp_done;
        logic        exp_err;
        logic [2:0]  exp_eidx;
        logic [2:0]  exp_addr;
        int          exp_wr;
        int          exp_nreq;
        logic [7:0]  r0, v0, r1, v1;
        int          off;
    } vec_t;

    vec_t vec [5];
    int   base;

    initial begin
        n_pass = 0;
        n_tot  = 0;
        n_req  = 0;
        cyc    = 0;

        vec[0].t = '{16'h1280, 16'h1101, 16'hFFFF, 16'h0, 16'h0,
                     16'h0, 16'h0, 16'h0};
        vec[0].nack = 8'hEE; vec[0].exp_done = 1; vec[0].exp_err = 0;
        vec[0].exp_eidx = 0; vec[0].exp_addr = 2; vec[0].exp_wr = 2;
        vec[0].exp_nreq = 2; vec[0].r0 = 8'h12; vec[0].v0 = 8'h80;
        vec[0].r1 = 8'h11; vec[0].v1 = 8'h01; vec[0].off = RSTW + 2;

        vec[1].t = '{16'hFE03, 16'h40D0, 16'hFFFF, 16'h0, 16'h0,
                     16'h0, 16'h0, 16'h0};
        vec[1].nack = 8'hEE; vec[1].exp_done = 1; vec[1].exp_err = 0;
        vec[1].exp_eidx = 0; vec[1].exp_addr = 2; vec[1].exp_wr = 1;
        vec[1].exp_nreq = 1; vec[1].r0 = 8'h40; vec[1].v0 = 8'hD0;
        vec[1].r1 = 8'h00; vec[1].v1 = 8'h00;
        vec[1].off = RSTW + 5 + 3 * UNIT;

        vec[2].t = '{16'h1280, 16'h3344, 16'hFFFF, 16'h0, 16'h0,
                     16'h0, 16'h0, 16'h0};
        vec[2].nack = 8'h33; vec[2].exp_done = 0; vec[2].exp_err = 1;
        vec[2].exp_eidx = 1; vec[2].exp_addr = 1; vec[2].exp_wr = 1;
        vec[2].exp_nreq = 5; vec[2].r0 = 8'h12; vec[2].v0 = 8'h80;
        vec[2].r1 = 8'h33; vec[2].v1 = 8'h44; vec[2].off = RSTW + 2;

        vec[3].t = '{16'h2000, 16'h2101, 16'h2202, 16'h2303, 16'h2404,
                     16'h2505, 16'h2606, 16'h2707};
        vec[3].nack = 8'hEE; vec[3].exp_done = 1; vec[3].exp_err = 0;
        vec[3].exp_eidx = 0; vec[3].exp_addr = 7; vec[3].exp_wr = 8;
        vec[3].exp_nreq = 8; vec[3].r0 = 8'h20; vec[3].v0 = 8'h00;
        vec[3].r1 = 8'h21; vec[3].v1 = 8'h01; vec[3].off = RSTW + 2;

        vec[4].t = '{16'hFE00, 16'h55AA, 16'hFFFF, 16'h0, 16'h0,
                     16'h0, 16'h0, 16'h0};
        vec[4].nack = 8'hEE; vec[4].exp_done = 1; vec[4].exp_err = 0;
        vec[4].exp_eidx = 0; vec[4].exp_addr = 2; vec[4].exp_wr = 1;
        vec[4].exp_nreq = 1; vec[4].r0 = 8'h55; vec[4].v0 = 8'hAA;
        vec[4].r1 = 8'h00; vec[4].v1 = 8'h00; vec[4].off = RSTW + 5;

        start    = 1'b0;
        reset    = 1'b1;
        nack_reg = vec[0].nack;
        for (int j = 0; j < DEPTH; j++) tbl[j] = vec[0].t[j];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_eidx", 32'(err_index), 0);
        chk("rst_wr", 32'(wr_count), 0);
        chk("rst_pwdn", 32'(cam_pwdn), 1);
        chk("rst_rstn", 32'(cam_rstn), 0);
        chk("rst_addr", 32'(tbl_addr), 0);
        chk("rst_req", 32'(sccb_req), 0);
        chk("rst_reg", 32'(sccb_reg), 0);
        chk("rst_wdata", 32'(sccb_wdata), 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            base = n_req;
            if (i > 0) begin
                nack_reg = vec[i].nack;
                for (int j = 0; j < DEPTH; j++) tbl[j] = vec[i].t[j];
                pulse_start();
                chk($sformatf("v%0d_busy_rise", i), 32'(busy), 1);
                chk($sformatf("v%0d_done_clr", i), 32'(done), 0);
                chk($sformatf("v%0d_err_clr", i), 32'(error), 0);
                chk($sformatf("v%0d_wr_clr", i), 32'(wr_count), 0);
            end
            wait_end($sformatf("v%0d_timeout", i));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vec[i].exp_done));
            chk($sformatf("v%0d_error", i), 32'(error), 32'(vec[i].exp_err));
            chk($sformatf("v%0d_wr", i), 32'(wr_count), 32'(vec[i].exp_wr));
            chk($sformatf("v%0d_nreq", i), 32'(n_req - base),
                32'(vec[i].exp_nreq));
            chk($sformatf("v%0d_addr", i), 32'(tbl_addr),
                32'(vec[i].exp_addr));
            if (vec[i].exp_err)
                chk($sformatf("v%0d_eidx", i), 32'(err_index),
                    32'(vec[i].exp_eidx));
            chk($sformatf("v%0d_reg0", i), 32'(reg_log[base]),
                32'(vec[i].r0));
            chk($sformatf("v%0d_val0", i), 32'(val_log[base]),
                32'(vec[i].v0));
            if (vec[i].exp_nreq > 1) begin
                chk($sformatf("v%0d_reg1", i), 32'(reg_log[base + 1]),
                    32'(vec[i].r1));
                chk($sformatf("v%0d_val1", i), 32'(val_log[base + 1]),
                    32'(vec[i].v1));
            end
            chk($sformatf("v%0d_pwdn_len", i), 32'(pwdn_fall - busy_rise),
                32'(PWDN));
            chk($sformatf("v%0d_rst_half", i), 32'(rstn_rise - pwdn_fall),
                32'(RSTW / 2));
            chk($sformatf("v%0d_req_off", i),
                32'(rise_log[base] - pwdn_fall), 32'(vec[i].off));
        end

        // start while a write is in flight must be ignored
        nack_reg = 8'hEE;
        for (int j = 0; j < DEPTH; j++) tbl[j] = vec[0].t[j];
        pulse_start();
        base = n_req;
        wait_req("a_req_timeout");
        pulse_start();
        chk("a_pwdn_stays_low", 32'(cam_pwdn), 0);
        chk("a_busy", 32'(busy), 1);
        chk("a_req_held", 32'(sccb_req), 1);
        wait_end("a_timeout");
        chk("a_done", 32'(done), 1);
        chk("a_wr", 32'(wr_count), 2);
        chk("a_nreq", 32'(n_req - base), 2);

        // reset in the middle of a write aborts and auto-restarts
        pulse_start();
        wait_req("b_req_timeout");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("b_req", 32'(sccb_req), 0);
        chk("b_pwdn", 32'(cam_pwdn), 1);
        chk("b_rstn", 32'(cam_rstn), 0);
        chk("b_busy", 32'(busy), 0);
        chk("b_wr", 32'(wr_count), 0);
        chk("b_addr", 32'(tbl_addr), 0);
        reset = 1'b0;
        base  = n_req;
        wait_end("b_timeout");
        chk("b_done", 32'(done), 1);
        chk("b_wr_after", 32'(wr_count), 2);
        chk("b_nreq", 32'(n_req - base), 2);
        chk("b_pwdn_len", 32'(pwdn_fall - busy_rise), 32'(PWDN));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
